// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit core: datapath sizes, register names, ALU opcodes.
package cpu8_pkg;

    localparam int DW = 8;
    localparam int AW = 2;

    localparam logic [AW-1:0] REG_A  = 2'd0;
    localparam logic [AW-1:0] REG_B  = 2'd1;
    localparam logic [AW-1:0] REG_C  = 2'd2;
    localparam logic [AW-1:0] REG_SP = 2'd3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

endpackage

// File: rtl/operand_bypass.sv
// One operand's forwarding mux: EX beats MEM beats WB beats the regfile read.
// Purely combinational.
module operand_bypass #(
    parameter int DW = cpu8_pkg::DW,
    parameter int AW = cpu8_pkg::AW
) (
    input  logic          use_i,
    input  logic [AW-1:0] rs_i,
    input  logic          ex_fwd_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic [DW-1:0] ex_dat_i,
    input  logic          mem_fwd_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic [DW-1:0] mem_dat_i,
    input  logic          wb_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [DW-1:0] rf_dat_i,
    output logic [DW-1:0] opnd_o
);

    logic ex_hit, mem_hit, wb_hit;

    assign ex_hit  = use_i & ex_fwd_i  & (ex_rd_i  == rs_i);
    assign mem_hit = use_i & mem_fwd_i & (mem_rd_i == rs_i);
    assign wb_hit  = use_i & wb_en_i   & (wb_addr_i == rs_i);

    always_comb begin
        opnd_o = rf_dat_i;
        if (ex_hit)
            opnd_o = ex_dat_i;
        else if (mem_hit)
            opnd_o = mem_dat_i;
        else if (wb_hit)
            opnd_o = wb_dat_i;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand fetch: regfile read, EX/MEM/WB bypass, load-use bubble, ID/EX register.
// One-edge latency into ex_*; hold freezes ID/EX, flush kills it.
module operand_fetch_stage #(
    parameter int DW = cpu8_pkg::DW,
    parameter int AW = cpu8_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic          id_use_imm,
    input  logic [DW-1:0] id_imm,
    input  logic [2:0]    id_alu_op,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    output logic [AW-1:0] rd_addr1,
    output logic [AW-1:0] rd_addr2,
    input  logic [DW-1:0] rd_d1,
    input  logic [DW-1:0] rd_d2,
    input  logic [DW-1:0] ex_alu_result,
    input  logic          mem_valid,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          hold,
    input  logic          flush,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic [AW-1:0] ex_rd,
    output logic [2:0]    ex_alu_op,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [15:0]   bubble_cnt
);

    logic          ex_valid_q, ex_valid_d;
    logic          ex_reg_write_q, ex_reg_write_d;
    logic          ex_mem_read_q, ex_mem_read_d;
    logic [AW-1:0] ex_rd_q, ex_rd_d;
    logic [2:0]    ex_alu_op_q, ex_alu_op_d;
    logic [DW-1:0] ex_a_q, ex_a_d;
    logic [DW-1:0] ex_b_q, ex_b_d;
    logic [15:0]   bubble_cnt_q, bubble_cnt_d;

    logic          ex_fwd, mem_fwd, hazard;
    logic [DW-1:0] opnd1, opnd2;

    assign rd_addr1 = id_rs1;
    assign rd_addr2 = id_rs2;

    // A load in EX has no data yet, so it is never a forwarding source.
    assign ex_fwd  = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;
    assign mem_fwd = mem_valid & mem_reg_write;

    assign hazard = ex_valid_q & ex_mem_read_q & ex_reg_write_q &
                    ((id_use_rs1 & (ex_rd_q == id_rs1)) |
                     (id_use_rs2 & ~id_use_imm & (ex_rd_q == id_rs2)));

    assign id_ready = ~hold & (flush | ~hazard);

    operand_bypass #(.DW(DW), .AW(AW)) u_byp1 (
        .use_i     (id_use_rs1),
        .rs_i      (id_rs1),
        .ex_fwd_i  (ex_fwd),
        .ex_rd_i   (ex_rd_q),
        .ex_dat_i  (ex_alu_result),
        .mem_fwd_i (mem_fwd),
        .mem_rd_i  (mem_rd),
        .mem_dat_i (mem_result),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_dat_i  (wb_data),
        .rf_dat_i  (rd_d1),
        .opnd_o    (opnd1)
    );

    operand_bypass #(.DW(DW), .AW(AW)) u_byp2 (
        .use_i     (id_use_rs2),
        .rs_i      (id_rs2),
        .ex_fwd_i  (ex_fwd),
        .ex_rd_i   (ex_rd_q),
        .ex_dat_i  (ex_alu_result),
        .mem_fwd_i (mem_fwd),
        .mem_rd_i  (mem_rd),
        .mem_dat_i (mem_result),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_dat_i  (wb_data),
        .rf_dat_i  (rd_d2),
        .opnd_o    (opnd2)
    );

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_rd_d        = ex_rd_q;
        ex_alu_op_d    = ex_alu_op_q;
        ex_a_d         = ex_a_q;
        ex_b_d         = ex_b_q;
        bubble_cnt_d   = bubble_cnt_q;

        if (flush) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end else if (hold) begin
            ex_valid_d = ex_valid_q;
        end else if (hazard) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            if (bubble_cnt_q != 16'hFFFF)
                bubble_cnt_d = bubble_cnt_q + 16'd1;
        end else if (id_valid) begin
            ex_valid_d     = 1'b1;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
            ex_rd_d        = id_rd;
            ex_alu_op_d    = id_alu_op;
            ex_a_d         = opnd1;
            ex_b_d         = id_use_imm ? id_imm : opnd2;
        end else begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_rd_q        <= '0;
            ex_alu_op_q    <= '0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_rd_q        <= ex_rd_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_rd        = ex_rd_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign ex_a         = ex_a_q;
    assign ex_b         = ex_b_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule
